// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 fetch types and defaults
package riscv_pkg;

   typedef logic [31:0] xlen_t;

   localparam xlen_t DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      xlen_t       pc;
      logic [31:0] instr;
      logic        err;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries; clear overrides push/pop
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         push,
   input  fetch_entry_t din,
   input  logic         pop,
   output fetch_entry_t dout,
   output logic [CW-1:0] count,
   output logic         empty,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop frees the slot the push needs, so push-while-full is legal with a pop.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/imem_prefetch_buffer.sv
// rtl/imem_prefetch_buffer.sv - sequential instruction prefetcher with redirect flush
module imem_prefetch_buffer
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            mem_req_valid,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_req_ready,
   input  logic            mem_rsp_valid,
   input  logic [31:0]     mem_rsp_data,
   input  logic            mem_rsp_err,
   output logic            out_valid,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_instr,
   output logic            out_err,
   input  logic            out_ready
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [XLEN-1:0] steer_pc;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   fifo_count;
   logic [CW-1:0]   issue_inc;
   logic [CW-1:0]   rsp_inc;
   logic [CW:0]     occupancy;
   logic            issue;
   logic            dropping;
   logic            push;
   logic            pop;
   logic            fifo_empty;
   logic            fifo_full;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   assign steer_pc  = {redirect_pc[XLEN-1:2], 2'b00};
   // Outstanding requests (including ones to be dropped) reserve a FIFO slot,
   // so a response always has room and the bus needs no back-pressure.
   assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};

   assign mem_req_valid = !rst && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
   assign mem_req_addr  = fetch_pc;
   assign issue         = mem_req_valid && mem_req_ready;
   assign issue_inc     = CW'(issue);
   assign rsp_inc       = CW'(mem_rsp_valid);

   assign dropping   = (drop_cnt != '0);
   assign push       = mem_rsp_valid && !dropping && !redirect_valid && (!fifo_full || pop);
   assign pop        = out_valid && out_ready && !redirect_valid;
   assign push_entry = '{pc: rsp_pc, instr: mem_rsp_data, err: mem_rsp_err};

   assign out_valid = !fifo_empty;
   assign out_pc    = head.pc;
   assign out_instr = head.instr;
   assign out_err   = head.err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= steer_pc;
         rsp_pc   <= steer_pc;
         inflight <= inflight - rsp_inc;
         drop_cnt <= inflight - rsp_inc;
      end else begin
         if (issue) begin
            fetch_pc <= fetch_pc + XLEN'(4);
         end
         if (push) begin
            rsp_pc <= rsp_pc + XLEN'(4);
         end
         if (mem_rsp_valid && dropping) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
         inflight <= inflight + issue_inc - rsp_inc;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (redirect_valid),
      .push  (push),
      .din   (push_entry),
      .pop   (pop),
      .dout  (head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// tb/tb_imem_prefetch_buffer.sv - scoreboard bench for imem_prefetch_buffer
module tb_imem_prefetch_buffer;
   import riscv_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready = 1'b0;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        mem_rsp_err = 1'b0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_err;
   logic        out_ready = 1'b0;

   always #5 clk = ~clk;

   imem_prefetch_buffer #(
      .XLEN     (32),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .mem_rsp_err    (mem_rsp_err),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_err        (out_err),
      .out_ready      (out_ready)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          drop;
   } req_t;

   req_t         pend[$];
   fetch_entry_t exp_q[$];
   logic [31:0]  m_fetch_pc;
   int           cyc, last_due, hs_cnt, pop_cnt, first_hs, first_ov;
   int           lat;
   bit           rdy, ordy, redir, want_first;
   logic [31:0]  redir_pc, first_pc;
   int           n_checks = 0;
   int           n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
   endfunction

   function automatic logic err_of(input logic [31:0] a);
      return a == 32'hFFFF_FFFC;
   endfunction

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      mem_rsp_valid  = 1'b0;
      mem_req_ready  = 1'b0;
      out_ready      = 1'b0;
      @(posedge clk);
      #1;
      check("rst_req_valid", mem_req_valid, 0);
      check("rst_req_addr", mem_req_addr, 32'h0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_pc", out_pc, 0);
      check("rst_out_instr", out_instr, 0);
      check("rst_out_err", out_err, 0);
      @(negedge clk);
      rst = 1'b0;
      pend.delete();
      exp_q.delete();
      m_fetch_pc = 32'h0;
      cyc        = 0;
      last_due   = -1;
      first_hs   = -1;
      first_ov   = -1;
      want_first = 0;
      redir      = 0;
   endtask

   // Called at a falling edge; drives one cycle and advances the model at the rising edge.
   task automatic cycle();
      bit           hs, rsp_v;
      req_t         nr, rr;
      fetch_entry_t e;
      redirect_valid = redir;
      redirect_pc    = redir_pc;
      mem_req_ready  = rdy;
      out_ready      = ordy;
      mem_rsp_valid  = 1'b0;
      #1;
      check("req_valid", mem_req_valid, 32'(!redir && (exp_q.size() + pend.size() < DEPTH)));
      if (mem_req_valid) check("req_addr", mem_req_addr, m_fetch_pc);
      check("out_valid", out_valid, 32'(exp_q.size() != 0));
      if (out_valid && first_ov < 0) first_ov = cyc;
      hs = mem_req_valid && rdy;
      if (hs) begin
         nr.addr = m_fetch_pc;
         nr.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
         nr.drop = 0;
         pend.push_back(nr);
         last_due   = nr.due;
         m_fetch_pc = m_fetch_pc + 32'd4;
         hs_cnt++;
         if (first_hs < 0) first_hs = cyc;
      end
      rsp_v = (pend.size() != 0) && (pend[0].due <= cyc);
      if (rsp_v) begin
         rr = pend.pop_front();
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = instr_of(rr.addr);
         mem_rsp_err   = err_of(rr.addr);
      end else begin
         mem_rsp_data = $urandom;
         mem_rsp_err  = 1'b0;
      end
      if (out_valid && ordy && !redir && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("out_pc", out_pc, e.pc);
         check("out_instr", out_instr, e.instr);
         check("out_err", out_err, 32'(e.err));
         if (want_first) begin
            check("first_pc_after_redirect", out_pc, first_pc);
            want_first = 0;
         end
         pop_cnt++;
      end
      if (redir) begin
         exp_q.delete();
         foreach (pend[i]) pend[i].drop = 1;
         m_fetch_pc = {redir_pc[31:2], 2'b00};
      end else if (rsp_v && !rr.drop) begin
         exp_q.push_back('{pc: rr.addr, instr: instr_of(rr.addr), err: err_of(rr.addr)});
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   initial begin
      int ndrop;
      lat = 1; rdy = 0; ordy = 0; redir = 0; redir_pc = '0; hs_cnt = 0; pop_cnt = 0;

      // Streaming with 1-cycle latency
      do_reset();
      rdy = 1; lat = 1; ordy = 1; pop_cnt = 0;
      run(12);
      check("A_first_latency", 32'(first_ov - first_hs), 2);
      check("A_pops", 32'(pop_cnt), 10);

      // Back-pressure fills exactly DEPTH slots, then drains in order
      do_reset();
      rdy = 1; lat = 0; ordy = 0; hs_cnt = 0;
      run(8);
      check("B_handshakes_full", 32'(hs_cnt), DEPTH);
      ordy = 1; want_first = 1; first_pc = 32'h0;
      run(8);

      // Redirect with three requests outstanding
      do_reset();
      rdy = 1; lat = 3; ordy = 1;
      run(3);
      redir = 1; redir_pc = 32'h0000_0103;
      cycle();
      redir = 0; want_first = 1; first_pc = 32'h0000_0100;
      run(12);

      // Redirect coinciding with a response and a pop, FIFO holding two
      do_reset();
      rdy = 1; lat = 2; ordy = 0;
      run(4);
      redir = 1; ordy = 1; redir_pc = 32'h0000_0200;
      cycle();
      ndrop = 0;
      foreach (pend[i]) if (pend[i].drop) ndrop++;
      check("D_drop_cnt", 32'(u_dut.drop_cnt), 32'(ndrop));
      check("D_drop_cnt_value", 32'(u_dut.drop_cnt), 1);
      redir = 0; want_first = 1; first_pc = 32'h0000_0200;
      run(10);

      // Bus stall holds the request stable
      do_reset();
      rdy = 0; lat = 1; ordy = 1; hs_cnt = 0;
      run(5);
      check("E_no_handshake", 32'(hs_cnt), 0);
      rdy = 1;
      run(1);
      check("E_single_handshake", 32'(hs_cnt), 1);

      // Wrap through the top of the address space with a faulting fetch
      redir = 1; redir_pc = 32'hFFFF_FFF8;
      cycle();
      redir = 0; want_first = 1; first_pc = 32'hFFFF_FFF8;
      run(12);

      // Random traffic with occasional redirects
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rdy      = ($urandom_range(0, 3) != 0);
         ordy     = ($urandom_range(0, 3) != 0);
         lat      = $urandom_range(0, 3);
         redir    = ($urandom_range(0, 19) == 0);
         redir_pc = (i % 50 == 7) ? 32'hFFFF_FFF3 : $urandom;
         cycle();
      end
      redir = 0; rdy = 1; ordy = 1;
      run(12);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_prefetch_buffer.md
Name: imem_prefetch_buffer

Overview:
Sequential instruction prefetcher between the instruction memory bus and the core's IF stage. Issues word-aligned fetches ahead of consumption with a variable-latency, in-order request/response bus. Buffers returned words with their PCs in a small FIFO. Flushes and re-steers on branch/jump redirects from EX, silently discarding responses still in flight.

Parameters:
XLEN, 32, datapath and address width.
DEPTH, 4, FIFO entries; also the maximum number of requests in flight plus buffered entries. Power of two, at least 2.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
redirect_valid  in  1  flush and re-steer request from EX
redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored and forced 0
mem_req_valid  out  1  fetch request valid
mem_req_addr  out  XLEN  fetch word address
mem_req_ready  in  1  bus accepts request
mem_rsp_valid  in  1  in-order response valid; no back-pressure
mem_rsp_data  in  32  instruction word
mem_rsp_err  in  1  bus error for this response
out_valid  out  1  instruction available to IF
out_pc  out  XLEN  PC of head entry
out_instr  out  32  instruction of head entry
out_err  out  1  fetch fault of head entry
out_ready  in  1  IF consumes head; driven as ~stall_if

Behaviour:
- Reset values (async, on rst):
  - fetch_pc = RESET_PC; rsp_pc = RESET_PC.
  - FIFO empty; inflight = 0; drop_cnt = 0.
  - Outputs: mem_req_valid = 0, mem_req_addr = RESET_PC, out_valid = 0, out_pc = 0, out_instr = 0, out_err = 0.
- Credit rule:
  - mem_req_valid = !redirect_valid && (fifo_count + inflight < DEPTH).
  - inflight includes responses marked for dropping. The FIFO therefore never overflows, so mem_rsp_valid is always accepted.
- Issue:
  - mem_req_addr = fetch_pc (registered).
  - On mem_req_valid && mem_req_ready: fetch_pc += 4 and inflight += 1.
  - Address is held stable while valid && !ready. It may change only on a redirect, which deasserts valid for that cycle; the bus must tolerate withdrawal.
- Response:
  - Each mem_rsp_valid decrements inflight.
  - If drop_cnt > 0: discard the response, drop_cnt -= 1.
  - Otherwise: push {rsp_pc, mem_rsp_data, mem_rsp_err} into the FIFO, then rsp_pc += 4.
- Output:
  - out_* reflect the FIFO head; out_valid = !empty.
  - Pop on out_valid && out_ready.
  - Contents are undefined but stable while out_valid = 0.
- Latency:
  - Request handshake in cycle T with response in T+L gives out_valid in T+L+1.
  - No combinational path from mem_rsp_* to out_*.
- Redirect in cycle T (highest priority):
  - FIFO cleared at end of T; any pop or push in T is cancelled.
  - fetch_pc and rsp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_cnt = inflight - mem_rsp_valid (the response arriving in T is discarded).
  - No request issued in T; the first new request is in T+1.
- Simultaneous events (no redirect):
  - Push and pop in the same cycle keep the count unchanged, even when full.
  - Issue and response in the same cycle leave inflight unchanged.
- Width and wrap:
  - PCs wrap modulo 2^XLEN; 32'hFFFF_FFFC + 4 = 0.
  - inflight, drop_cnt and fifo_count are $clog2(DEPTH)+1 bits.
- Errors:
  - out_err only tags the entry. Fetch continues sequentially; trap handling is downstream.
- Reset mid-operation: all state returns to reset values immediately, and responses arriving after reset deasserts are pushed as new data. The bus must therefore be reset together with the block.

Decomposition:
- riscv_pkg additions:
  - fetch_entry_t struct {xlen_t pc; logic [31:0] instr; logic err;}.
  - RESET_PC localparam default.
  - Reuse xlen_t.
- One sub-module: fetch_fifo. Synchronous FIFO of fetch_entry_t, parameter DEPTH, with push, pop, clear, count, empty and full. Clear has priority over push/pop.

Test Plan:
- Reset release, mem_req_ready=1, fixed 1-cycle response latency, out_ready=1 -> requests to 0x0, 0x4, 0x8, ...; out_pc sequence 0x0, 0x4, 0x8 with matching out_instr; first out_valid 2 cycles after first handshake.
- out_ready=0, zero-latency bus -> exactly DEPTH=4 handshakes (0x0–0xC), then mem_req_valid=0. Raise out_ready: 4 pops in order, fetch resumes at 0x10.
- 3 requests in flight (0x0, 0x4, 0x8), then redirect_valid with redirect_pc=0x103 -> next request addr 0x100; the 3 old responses are dropped; first out_pc = 0x100.
- Redirect in the same cycle as a response and a pop with FIFO holding 2 entries -> FIFO empty next cycle, drop_cnt = inflight-1, no stale PC ever appears at out_*.
- mem_req_ready held low 5 cycles -> mem_req_valid=1 and mem_req_addr constant throughout; single handshake when ready rises.
- Redirect to 0xFFFF_FFF8, response for 0xFFFF_FFFC with mem_rsp_err=1 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC (out_err=1), 0x0000_0000.
